// File: rtl/vector_add_arbiter.sv
// rtl/vector_add_arbiter.sv - round-robin sharing of one pipelined vector adder among NUM_REQ requesters
// Grants one requester per cycle, registers its operands into the adder and tags results with the owner ID.
module vector_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int ADD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [96*NUM_REQ-1:0]   req_v1,
    input  logic [96*NUM_REQ-1:0]   req_v2,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    add_new_data,
    output logic [95:0]             add_v1,
    output logic [95:0]             add_v2,
    input  logic [95:0]             add_r,
    input  logic                    add_output_valid,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [95:0]             resp_r,
    output logic                    busy,
    output logic                    err
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;

    logic            new_data_q;
    logic [95:0]     v1_q;
    logic [95:0]     v2_q;
    logic [ID_W-1:0] issue_id_q;

    logic [ADD_LATENCY-1:0] tag_vld_q;
    logic [ID_W-1:0]        tag_id_q [ADD_LATENCY];

    logic            err_q;

    logic [95:0]     v1_arr [NUM_REQ];
    logic [95:0]     v2_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign v1_arr[i] = req_v1[96*i +: 96];
        assign v2_arr[i] = req_v2[96*i +: 96];
    end

    // Scan from the farthest offset back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (!en) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            new_data_q <= 1'b0;
            v1_q       <= '0;
            v2_q       <= '0;
            issue_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            new_data_q <= grant_vld;
            if (grant_vld) begin
                v1_q       <= v1_arr[grant_idx];
                v2_q       <= v2_arr[grant_idx];
                issue_id_q <= grant_idx;
            end
        end
    end

    // Tag pipeline depth equals adder latency so the tail lines up with add_output_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            for (int k = 0; k < ADD_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_vld_q[0] <= new_data_q;
            tag_id_q[0]  <= issue_id_q;
            for (int k = 1; k < ADD_LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (add_output_valid != tag_vld_q[ADD_LATENCY-1]) begin
            err_q <= 1'b1;
        end
    end

    assign add_new_data = new_data_q;
    assign add_v1       = v1_q;
    assign add_v2       = v2_q;
    assign resp_valid   = add_output_valid & tag_vld_q[ADD_LATENCY-1];
    assign resp_id      = tag_id_q[ADD_LATENCY-1];
    assign resp_r       = add_r;
    assign busy         = new_data_q | (|tag_vld_q);
    assign err          = err_q;

endmodule

// File: tb/tb_vector_add_arbiter.sv
// tb/tb_vector_add_arbiter.sv - scoreboard bench with a behavioural adder and round-robin reference model
module tb_vector_add_arbiter;

    localparam int NREQ = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [96*NREQ-1:0] req_v1 = '0;
    logic [96*NREQ-1:0] req_v2 = '0;
    logic [NREQ-1:0] req_ready;
    logic           add_new_data;
    logic [95:0]    add_v1, add_v2, add_r;
    logic           add_output_valid;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [95:0]    resp_r;
    logic           busy, err;

    vector_add_arbiter #(.NUM_REQ(NREQ), .ID_W(2), .ADD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_v1(req_v1), .req_v2(req_v2), .req_ready(req_ready),
        .add_new_data(add_new_data), .add_v1(add_v1), .add_v2(add_v2),
        .add_r(add_r), .add_output_valid(add_output_valid),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_r(resp_r),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] lane_sum(input logic [95:0] a, input logic [95:0] b);
        logic [95:0] r;
        for (int l = 0; l < 3; l++) r[32*l +: 32] = a[32*l +: 32] + b[32*l +: 32];
        return r;
    endfunction

    // Behavioural two-stage adder sharing the block's reset.
    logic        p1_v, p2_v, force_ov;
    logic [95:0] p1_r, p2_r;
    initial force_ov = 1'b0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_r <= '0; p2_r <= '0;
        end else begin
            p1_v <= add_new_data; p1_r <= lane_sum(add_v1, add_v2);
            p2_v <= p1_v;         p2_r <= p1_r;
        end
    end
    assign add_output_valid = p2_v | force_ov;
    assign add_r = p2_r;

    typedef struct { logic [1:0] id; logic [95:0] r; int due; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rv [NREQ];
    logic [95:0] a1 [NREQ];
    logic [95:0] a2 [NREQ];
    int          ptr = 0;
    int          last_grant = -100;
    logic        hold = 1'b0;
    logic        en_s = 1'b1;
    logic [NREQ-1:0] obs_ready;
    logic        obs_busy;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got id %0d r %0h expected no response (cycle %0d)", resp_id, resp_r, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_id !== e.id || resp_r !== e.r || cyc != e.due) begin
                    errors++;
                    $display("FAIL resp: got id %0d r %0h cycle %0d expected id %0d r %0h cycle %0d",
                             resp_id, resp_r, cyc, e.id, e.r, e.due);
                end
            end
        end
    end

    // One clock of stimulus plus reference-model prediction of the grant.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic exp_busy;
        @(posedge clk); #1;
        en = en_s;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = rv[i];
            req_v1[96*i +: 96] = a1[i];
            req_v2[96*i +: 96] = a2[i];
        end
        @(negedge clk);
        g = -1;
        if (en_s) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr + k) % NREQ;
                if (rv[i] && g < 0) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_ready = req_ready;
        obs_busy = busy;
        chk("req_ready", {124'd0, obs_ready}, {124'd0, exp_rdy});
        exp_busy = (cyc - last_grant >= 1) && (cyc - last_grant <= 3);
        chk("busy", {127'd0, obs_busy}, {127'd0, exp_busy});
        if (g >= 0) begin
            exp_t e;
            e.id = 2'(g);
            e.r = lane_sum(a1[g], a2[g]);
            e.due = cyc + 3;
            exp_q.push_back(e);
            ptr = (g + 1) % NREQ;
            last_grant = cyc;
            if (!hold) rv[g] = 1'b0;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        ptr = 0;
        last_grant = -100;
        hold = 1'b0;
        en_s = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0; a1[i] = '0; a2[i] = '0;
        end
        req_valid = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        clear_model();
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic rand_req(input int i);
        rv[i] = 1'b1;
        a1[i] = {$urandom, $urandom, $urandom};
        a2[i] = {$urandom, $urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_new_data", {127'd0, add_new_data}, 128'd0);
        chk("rst_v1", {32'd0, add_v1}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        chk("rst_resp", {125'd0, resp_valid, resp_id}, 128'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Single request with Q16.16 lanes {1,2,3} + {4,5,6}.
        rv[0] = 1'b1;
        a1[0] = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        a2[0] = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000};
        step();
        chk("single_ready", {124'd0, obs_ready}, 128'h1);
        idle(2);
        step();
        chk("single_resp_valid", {127'd0, resp_valid}, 128'd1);
        chk("single_resp_id", {126'd0, resp_id}, 128'd0);
        chk("single_resp_r", {32'd0, resp_r}, {32'd0, 32'h0009_0000, 32'h0007_0000, 32'h0005_0000});
        idle(3);

        // Fairness with all requesters held valid.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < NREQ; i++) rand_req(i);
        for (int k = 0; k < 8; k++) begin
            logic [NREQ-1:0] want;
            step();
            want = '0;
            want[k % NREQ] = 1'b1;
            chk("fair_order", {124'd0, obs_ready}, {124'd0, want});
        end
        hold = 1'b0;
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        idle(5);
        chk("fair_drained", 128'(exp_q.size()), 128'd0);

        // Pointer wrap: move pointer to 3, then offer 4'b1001.
        do_reset();
        rand_req(2);
        step();
        rand_req(3); rand_req(0);
        step();
        chk("wrap_first", {124'd0, obs_ready}, 128'h8);
        step();
        chk("wrap_second", {124'd0, obs_ready}, 128'h1);
        for (int i = 0; i < NREQ; i++) rand_req(i);
        step();
        chk("wrap_ptr_at_1", {124'd0, obs_ready}, 128'h2);
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        idle(5);
        chk("wrap_drained", 128'(exp_q.size()), 128'd0);

        // Enable drain after two issues.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < NREQ; i++) rand_req(i);
        idle(2);
        en_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_no_ready", {124'd0, obs_ready}, 128'd0);
            chk("drain_busy", {127'd0, obs_busy}, (k < 3) ? 128'd1 : 128'd0);
        end
        chk("drain_done", 128'(exp_q.size()), 128'd0);

        // Async reset between edges with two operations in flight.
        do_reset();
        for (int i = 0; i < NREQ; i++) rand_req(i);
        idle(2);
        en_s = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_new_data", {127'd0, add_new_data}, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_resp_valid", {127'd0, resp_valid}, 128'd0);
        chk("arst_v1", {32'd0, add_v1}, 128'd0);
        clear_model();
        #1;
        rst = 1'b0;
        idle(5);
        chk("arst_err", {127'd0, err}, 128'd0);

        // Randomised traffic with occasional enable drops.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!rv[i] && $urandom_range(1) == 1) rand_req(i);
            en_s = ($urandom_range(7) != 0);
            step();
        end
        en_s = 1'b1;
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        idle(5);
        chk("rand_drained", 128'(exp_q.size()), 128'd0);
        chk("rand_err", {127'd0, err}, 128'd0);

        // Valid from the adder with an empty tag pipeline.
        do_reset();
        idle(2);
        force_ov = 1'b1;
        step();
        force_ov = 1'b0;
        step();
        chk("mismatch_err", {127'd0, err}, 128'd1);
        idle(3);
        chk("mismatch_sticky", {127'd0, err}, 128'd1);
        do_reset();
        #1;
        chk("mismatch_cleared", {127'd0, err}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
